dprintf_4_arbiter: RTL and testbench
====================================

DPRINTF_4_ARBITER -- requirements
Module: dprintf_4_arbiter

Interface
REQ-001 The block SHALL have parameter PORT_OFFSET, default 16'd40, giving the per-port address stride used only when DPRINTF_ARB_ADDR_OFFSET_EN is defined.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports dprintf_reqN__valid, input, 1, requester N (N=0..3) request valid.
REQ-005 The block SHALL have ports dprintf_reqN__address, input, 16, requester N display address.
REQ-006 The block SHALL have ports dprintf_reqN__data_0 and dprintf_reqN__data_1, input, 64 each, requester N packed characters.
REQ-007 The block SHALL have port dprintf_req_ack, output, 4, bit N acknowledges requester N.
REQ-008 The block SHALL have port dprintf_req__valid, output, 1, merged request valid to the teletext dprintf engine.
REQ-009 The block SHALL have ports dprintf_req__address (16), dprintf_req__data_0 (64) and dprintf_req__data_1 (64), all outputs, carrying the merged request.
REQ-010 The block SHALL have port dprintf_ack, input, 1, engine acknowledge of the merged request.

Function
REQ-011 The block SHALL hold one holding register (valid, address, data_0, data_1, source index); the dprintf_req__* outputs SHALL be driven directly from it.
REQ-012 States SHALL be EMPTY (holding invalid) and FULL (holding valid); dprintf_req__valid SHALL be 1 exactly in FULL.
REQ-013 Load condition: state is EMPTY, or state is FULL with dprintf_ack=1 in the same cycle; this gives back-to-back transfers with no bubble.
REQ-014 On a load cycle with at least one reqN__valid=1, the winner SHALL be chosen round-robin, searching from (last_grant+1) mod 4 upward with wrap.
REQ-015 On that cycle the winner's request SHALL be captured into the holding register, dprintf_req_ack[winner] SHALL be 1 combinationally, and last_grant SHALL be updated to the winner.
REQ-016 dprintf_req_ack SHALL be one-hot or zero, and SHALL be zero on any cycle that is not a load cycle.
REQ-017 A FULL state with dprintf_ack=1 and no valid requester SHALL go to EMPTY next cycle.
REQ-018 Holding contents SHALL stay stable while FULL and dprintf_ack=0.
REQ-019 A requester SHALL hold valid and data until it sees its ack bit; a request whose valid is withdrawn before ack SHALL simply be skipped.
REQ-020 dprintf_ack while EMPTY SHALL be ignored.
REQ-021 Latency from an accepted request (EMPTY state, single requester) to dprintf_req__valid SHALL be 1 cycle.

Reset
REQ-022 While reset=1 the block SHALL set the state to EMPTY, last_grant to 3 (so port 0 wins first), and the holding address and data to 0.
REQ-023 While reset=1, dprintf_req__valid and dprintf_req_ack SHALL be 0.
REQ-024 Reset asserted while FULL SHALL discard the pending request without any further ack.

Configuration
REQ-025 With DPRINTF_ARB_ADDR_OFFSET_EN defined, the captured address SHALL be reqN__address + N*PORT_OFFSET, modulo 2^16 (wrap, no saturation).
REQ-026 Without DPRINTF_ARB_ADDR_OFFSET_EN, the captured address SHALL be reqN__address unmodified.

Verification
REQ-027 Scenario 1: after reset, req0 valid with address 0x0010 and data_0 0x41424344_FFFFFFFF.
- Required response: ack[0] high in that cycle; next cycle dprintf_req__valid=1 with identical fields; dprintf_ack=1 then gives EMPTY.
REQ-028 Scenario 2: all four requesters held valid, dprintf_ack tied 1.
- Required response: grants are 0,1,2,3,0 on consecutive cycles; dprintf_req__valid stays high with no bubble.
REQ-029 Scenario 3: req2 valid while dprintf_ack is held 0 for 5 cycles.
- Required response: outputs stay stable; dprintf_req_ack=0 for those 5 cycles; the next request is accepted only in the cycle dprintf_ack=1.
REQ-030 Scenario 4: reset pulsed while FULL with source req1.
- Required response: dprintf_req__valid=0 next cycle; a subsequent concurrent req1/req3 grants req1 first (last_grant=3).
REQ-031 Scenario 5: with DPRINTF_ARB_ADDR_OFFSET_EN and PORT_OFFSET=40, req3 address 0xFFF0.
- Required response: output address is 0x0068 (wrapped).
- Without the macro, the output address is 0xFFF0.

Source files
------------

// File: rtl/dprintf_4_arbiter.sv
// Four-way round-robin arbiter into a single holding register that feeds the dprintf engine.
// Optional per-port address offset enabled by DPRINTF_ARB_ADDR_OFFSET_EN; 1-cycle latency, reloads on engine ack.
module dprintf_4_arbiter #(
    parameter logic [15:0] PORT_OFFSET = 16'd40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dprintf_req0__valid,
    input  logic [15:0] dprintf_req0__address,
    input  logic [63:0] dprintf_req0__data_0,
    input  logic [63:0] dprintf_req0__data_1,
    input  logic        dprintf_req1__valid,
    input  logic [15:0] dprintf_req1__address,
    input  logic [63:0] dprintf_req1__data_0,
    input  logic [63:0] dprintf_req1__data_1,
    input  logic        dprintf_req2__valid,
    input  logic [15:0] dprintf_req2__address,
    input  logic [63:0] dprintf_req2__data_0,
    input  logic [63:0] dprintf_req2__data_1,
    input  logic        dprintf_req3__valid,
    input  logic [15:0] dprintf_req3__address,
    input  logic [63:0] dprintf_req3__data_0,
    input  logic [63:0] dprintf_req3__data_1,
    output logic [3:0]  dprintf_req_ack,
    output logic        dprintf_req__valid,
    output logic [15:0] dprintf_req__address,
    output logic [63:0] dprintf_req__data_0,
    output logic [63:0] dprintf_req__data_1,
    input  logic        dprintf_ack
);

`ifdef DPRINTF_ARB_ADDR_OFFSET_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] hold_addr_q, hold_addr_d;
    logic [63:0] hold_d0_q, hold_d0_d;
    logic [63:0] hold_d1_q, hold_d1_d;
    logic [1:0]  hold_src_q, hold_src_d;

    logic [3:0]  req_vld;
    logic [15:0] req_addr [4];
    logic [63:0] req_d0 [4];
    logic [63:0] req_d1 [4];

    logic        load;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic [1:0]  rr_idx;
    logic [15:0] cap_addr;

    assign req_vld     = {dprintf_req3__valid, dprintf_req2__valid,
                          dprintf_req1__valid, dprintf_req0__valid};
    assign req_addr[0] = dprintf_req0__address;
    assign req_addr[1] = dprintf_req1__address;
    assign req_addr[2] = dprintf_req2__address;
    assign req_addr[3] = dprintf_req3__address;
    assign req_d0[0]   = dprintf_req0__data_0;
    assign req_d0[1]   = dprintf_req1__data_0;
    assign req_d0[2]   = dprintf_req2__data_0;
    assign req_d0[3]   = dprintf_req3__data_0;
    assign req_d1[0]   = dprintf_req0__data_1;
    assign req_d1[1]   = dprintf_req1__data_1;
    assign req_d1[2]   = dprintf_req2__data_1;
    assign req_d1[3]   = dprintf_req3__data_1;

    // The source index of the last capture doubles as the round-robin pointer.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        rr_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = hold_src_q + 2'(k);
            if (!win_vld && req_vld[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
    end

    assign load     = !reset && ((state_q == ST_EMPTY) || dprintf_ack);
    assign cap_addr = req_addr[win_idx] + (OFFSET_EN ? (16'(win_idx) * PORT_OFFSET) : 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            hold_addr_q <= 16'd0;
            hold_d0_q   <= 64'd0;
            hold_d1_q   <= 64'd0;
            hold_src_q  <= 2'd3;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_d0_q   <= hold_d0_d;
            hold_d1_q   <= hold_d1_d;
            hold_src_q  <= hold_src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_d0_d   = hold_d0_q;
        hold_d1_d   = hold_d1_q;
        hold_src_d  = hold_src_q;
        if (load) begin
            state_d = win_vld ? ST_FULL : ST_EMPTY;
            if (win_vld) begin
                hold_addr_d = cap_addr;
                hold_d0_d   = req_d0[win_idx];
                hold_d1_d   = req_d1[win_idx];
                hold_src_d  = win_idx;
            end
        end
    end

    always_comb begin
        dprintf_req_ack      = 4'd0;
        dprintf_req__valid   = (state_q == ST_FULL);
        dprintf_req__address = hold_addr_q;
        dprintf_req__data_0  = hold_d0_q;
        dprintf_req__data_1  = hold_d1_q;
        if (load && win_vld) begin
            dprintf_req_ack = 4'b0001 << win_idx;
        end
    end

endmodule

// File: tb/tb_dprintf_4_arbiter.sv
// Scoreboard bench for dprintf_4_arbiter: directed vectors push expected merged requests, a monitor checks them on engine ack.
module tb_dprintf_4_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rv;
    logic [15:0] ra [4];
    logic [63:0] rd0 [4];
    logic [63:0] rd1 [4];
    logic [3:0]  rack;
    logic        ov;
    logic [15:0] oa;
    logic [63:0] od0, od1;
    logic        eack;

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d0;
        logic [63:0] d1;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dprintf_4_arbiter #(.PORT_OFFSET(16'd40)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .dprintf_req0__valid   (rv[0]),
        .dprintf_req0__address (ra[0]),
        .dprintf_req0__data_0  (rd0[0]),
        .dprintf_req0__data_1  (rd1[0]),
        .dprintf_req1__valid   (rv[1]),
        .dprintf_req1__address (ra[1]),
        .dprintf_req1__data_0  (rd0[1]),
        .dprintf_req1__data_1  (rd1[1]),
        .dprintf_req2__valid   (rv[2]),
        .dprintf_req2__address (ra[2]),
        .dprintf_req2__data_0  (rd0[2]),
        .dprintf_req2__data_1  (rd1[2]),
        .dprintf_req3__valid   (rv[3]),
        .dprintf_req3__address (ra[3]),
        .dprintf_req3__data_0  (rd0[3]),
        .dprintf_req3__data_1  (rd1[3]),
        .dprintf_req_ack       (rack),
        .dprintf_req__valid    (ov),
        .dprintf_req__address  (oa),
        .dprintf_req__data_0   (od0),
        .dprintf_req__data_1   (od1),
        .dprintf_ack           (eack)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [15:0] a, input logic [63:0] d0, input logic [63:0] d1);
        txn_t t;
        t.a  = a;
        t.d0 = d0;
        t.d1 = d1;
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        rv    = 4'd0;
        eack  = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every engine handshake must match the oldest expected request.
    always @(negedge clk) begin
        if (!reset && ov === 1'b1 && eack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_txn: got addr %h, expected no transfer", oa);
            end else begin
                mon_e = exp_q.pop_front();
                chk("txn_addr", 64'(oa), 64'(mon_e.a));
                chk("txn_data_0", od0, mon_e.d0);
                chk("txn_data_1", od1, mon_e.d1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int          order [5];
        logic [15:0] s2_addr [4];
        logic [15:0] s3_a1, s3_a2, s4_a1, s4_a3, s5_a;
        order = '{0, 1, 2, 3, 0};
`ifdef DPRINTF_ARB_ADDR_OFFSET_EN
        s2_addr = '{16'h1000, 16'h1029, 16'h1052, 16'h107B};
        s3_a1 = 16'h2272; s3_a2 = 16'h3380;
        s4_a1 = 16'h0129; s4_a3 = 16'h037B;
        s5_a  = 16'h0068;
`else
        s2_addr = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
        s3_a1 = 16'h2222; s3_a2 = 16'h3330;
        s4_a1 = 16'h0101; s4_a3 = 16'h0303;
        s5_a  = 16'hFFF0;
`endif
        reset = 1'b1;
        rv    = 4'd0;
        eack  = 1'b0;
        for (int n = 0; n < 4; n++) begin
            ra[n] = 16'd0; rd0[n] = 64'd0; rd1[n] = 64'd0;
        end
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_valid", 64'(ov), 64'd0);
        chk("rst_ack", 64'(rack), 64'd0);
        chk("rst_addr", 64'(oa), 64'd0);
        chk("rst_data_0", od0, 64'd0);

        // Scenario 1: single request, one-cycle latency
        cyc();
        reset = 1'b0;
        rv = 4'b0001; ra[0] = 16'h0010;
        rd0[0] = 64'h41424344_FFFFFFFF; rd1[0] = 64'h01234567_89ABCDEF;
        exp_q.push_back(mk(16'h0010, 64'h41424344_FFFFFFFF, 64'h01234567_89ABCDEF));
        @(negedge clk);
        chk("s1_ack", 64'(rack), 64'h1);
        chk("s1_valid_before", 64'(ov), 64'd0);
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s1_valid", 64'(ov), 64'd1);
        chk("s1_addr", 64'(oa), 64'h0010);
        chk("s1_data_0", od0, 64'h41424344_FFFFFFFF);
        chk("s1_ack_idle", 64'(rack), 64'd0);
        cyc();
        eack = 1'b1;
        @(negedge clk);
        chk("s1_ack_none", 64'(rack), 64'd0);
        cyc();
        eack = 1'b0;
        @(negedge clk);
        chk("s1_empty", 64'(ov), 64'd0);

        // Scenario 2: all requesters valid, engine always ready
        do_reset();
        for (int n = 0; n < 4; n++) begin
            ra[n]  = 16'h1000 + 16'(n);
            rd0[n] = 64'hA0A0_0000_0000_0000 + 64'(n);
            rd1[n] = 64'h0B0B_0000_0000_0000 + 64'(n);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                rv = 4'hF;
                eack = 1'b1;
            end
            exp_q.push_back(mk(s2_addr[order[i]], 64'hA0A0_0000_0000_0000 + 64'(order[i]),
                               64'h0B0B_0000_0000_0000 + 64'(order[i])));
            @(negedge clk);
            chk("s2_grant", 64'(rack), 64'(4'b0001 << order[i]));
            if (i > 0) chk("s2_valid", 64'(ov), 64'd1);
        end
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s2_valid_tail", 64'(ov), 64'd1);
        chk("s2_ack_tail", 64'(rack), 64'd0);
        cyc();
        eack = 1'b0;
        @(negedge clk);
        chk("s2_drain", 64'(ov), 64'd0);

        // Scenario 3: engine stalls for five cycles
        cyc();
        rv = 4'b0100; ra[2] = 16'h2222;
        rd0[2] = 64'h1111_2222_3333_4444; rd1[2] = 64'h5555_6666_7777_8888;
        exp_q.push_back(mk(s3_a1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888));
        @(negedge clk);
        chk("s3_grant", 64'(rack), 64'h4);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                ra[2] = 16'h3330;
                rd0[2] = 64'hCAFE_F00D_0000_0001; rd1[2] = 64'hDEAD_BEEF_0000_0002;
            end
            @(negedge clk);
            chk("s3_hold_ack", 64'(rack), 64'd0);
            chk("s3_hold_valid", 64'(ov), 64'd1);
            chk("s3_hold_addr", 64'(oa), 64'(s3_a1));
            chk("s3_hold_data_0", od0, 64'h1111_2222_3333_4444);
        end
        cyc();
        eack = 1'b1;
        exp_q.push_back(mk(s3_a2, 64'hCAFE_F00D_0000_0001, 64'hDEAD_BEEF_0000_0002));
        @(negedge clk);
        chk("s3_accept", 64'(rack), 64'h4);
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s3_idle_ack", 64'(rack), 64'd0);
        cyc();
        eack = 1'b0;
        @(negedge clk);
        chk("s3_empty", 64'(ov), 64'd0);

        // Scenario 4: reset while holding a req1 request
        cyc();
        rv = 4'b0010; ra[1] = 16'h0BAD;
        @(negedge clk);
        chk("s4_grant", 64'(rack), 64'h2);
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s4_full", 64'(ov), 64'd1);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("s4_rst_ack", 64'(rack), 64'd0);
        cyc();
        reset = 1'b0;
        rv = 4'b1010; ra[1] = 16'h0101; ra[3] = 16'h0303;
        rd0[1] = 64'h1; rd1[1] = 64'h11; rd0[3] = 64'h3; rd1[3] = 64'h33;
        exp_q.push_back(mk(s4_a1, 64'h1, 64'h11));
        @(negedge clk);
        chk("s4_valid_after_rst", 64'(ov), 64'd0);
        chk("s4_first", 64'(rack), 64'h2);
        cyc();
        rv = 4'b1000; eack = 1'b1;
        exp_q.push_back(mk(s4_a3, 64'h3, 64'h33));
        @(negedge clk);
        chk("s4_second", 64'(rack), 64'h8);
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s4_ack_none", 64'(rack), 64'd0);
        cyc();
        eack = 1'b0;
        @(negedge clk);
        chk("s4_empty", 64'(ov), 64'd0);

        // Scenario 5: address wrap on req3
        do_reset();
        cyc();
        rv = 4'b1000; ra[3] = 16'hFFF0;
        rd0[3] = 64'h5A5A_5A5A_5A5A_5A5A; rd1[3] = 64'hA5A5_A5A5_A5A5_A5A5;
        exp_q.push_back(mk(s5_a, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5));
        @(negedge clk);
        chk("s5_grant", 64'(rack), 64'h8);
        cyc();
        rv = 4'd0;
        @(negedge clk);
        chk("s5_addr", 64'(oa), 64'(s5_a));
        cyc();
        eack = 1'b1;
        @(negedge clk);
        cyc();
        eack = 1'b0;
        @(negedge clk);
        chk("s5_empty", 64'(ov), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
